// File: rtl/lfsr_sync_checker_if.sv
// Receive-side bundle for lfsr_sync_checker: incoming PRBS beats, resync request and status outputs.
interface lfsr_sync_checker_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 valid_in;
  logic [WIDTH-1:0]     datain;
  logic                 resync;
  logic                 locked;
  logic                 err_pulse;
  logic                 error;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output valid_in, datain, resync,
    input  locked, err_pulse, error, err_count
  );

  modport slave (
    input  valid_in, datain, resync,
    output locked, err_pulse, error, err_count
  );
endinterface

// File: rtl/lfsr_sync_checker.sv
// Self-synchronising PRBS checker with SEARCH/LOCKED tracking and sticky error reporting.
// Define LFSR_SYNC_CHECKER_ERR_CNT_EN to build the saturating err_count; otherwise it reads 0.
module lfsr_sync_checker #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  lfsr_sync_checker_if.slave bus
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BAD_W  = $clog2(LOSS_COUNT + 1);
  // Fibonacci taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(32'h8020_0003);

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_e;

  function automatic logic [WIDTH-1:0] lfsr(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  state_e             state_q, state_d;
  logic               have_prev_q, have_prev_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic               err_pulse_q, err_pulse_d;
  logic               error_q, error_d;

  logic beat, compare, match;

  // resync swallows a coincident beat entirely.
  assign beat    = bus.valid_in & ~bus.resync;
  assign compare = beat & have_prev_q;
  assign match   = (bus.datain == expected_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      have_prev_q <= 1'b0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      expected_q  <= '0;
      err_pulse_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      expected_q  <= expected_d;
      err_pulse_q <= err_pulse_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    expected_d  = expected_q;
    err_pulse_d = 1'b0;
    error_d     = error_q;

    if (bus.resync) begin
      state_d     = SEARCH;
      have_prev_d = 1'b0;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      error_d     = 1'b0;
    end else if (beat) begin
      expected_d  = lfsr(bus.datain);
      have_prev_d = 1'b1;
      if (compare) begin
        unique case (state_q)
          SEARCH: begin
            if (!match) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == GOOD_W'(LOCK_COUNT - 1)) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              bad_cnt_d = '0;
            end else begin
              err_pulse_d = 1'b1;
              error_d     = 1'b1;
              if (bad_cnt_q == BAD_W'(LOSS_COUNT - 1)) begin
                state_d    = SEARCH;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
              end else begin
                bad_cnt_d = bad_cnt_q + BAD_W'(1);
              end
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  always_comb begin
    bus.locked    = (state_q == LOCKED);
    bus.err_pulse = err_pulse_q;
    bus.error     = error_q;
  end

`ifdef LFSR_SYNC_CHECKER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || bus.resync) begin
      err_cnt_q <= '0;
    end else if (err_pulse_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Bench for lfsr_sync_checker: directed scenarios plus a randomized tail, checked against a spec-level model.
// Two instances share stimulus: err_count width 16 and width 2 (saturation).
module tb_lfsr_sync_checker;

`ifdef LFSR_SYNC_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_sync_checker_if #(.WIDTH(32), .ERR_CNT_W(16)) bus_a ();
  lfsr_sync_checker_if #(.WIDTH(32), .ERR_CNT_W(2))  bus_b ();

  lfsr_sync_checker #(.WIDTH(32), .LOCK_COUNT(4), .LOSS_COUNT(4), .ERR_CNT_W(16)) dut_a (
    .clk(clk), .reset(rst), .bus(bus_a.slave)
  );
  lfsr_sync_checker #(.WIDTH(32), .LOCK_COUNT(4), .LOSS_COUNT(4), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .reset(rst), .bus(bus_b.slave)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Spec-level model state
  bit          m_locked, m_have, m_pulse, m_error;
  int          m_good, m_bad, m_cnt;
  logic [31:0] m_exp;

  logic [31:0] W [0:40];

  // Polynomial x^32 + x^22 + x^2 + x + 1, left-shifting Fibonacci register.
  function automatic logic [31:0] prbs_next(input logic [31:0] x);
    logic fb;
    fb = x[31] ^ x[21] ^ x[1] ^ x[0];
    return (x << 1) | {31'd0, fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit rs, input bit rr);
    bit m;
    int exp_a, exp_b;
    rst = rr;
    bus_a.valid_in = v; bus_a.datain = d; bus_a.resync = rs;
    bus_b.valid_in = v; bus_b.datain = d; bus_b.resync = rs;
    @(posedge clk);
    #1;
    m_pulse = 1'b0;
    if (rr || rs) begin
      m_locked = 1'b0; m_have = 1'b0; m_good = 0; m_bad = 0;
      m_error = 1'b0; m_cnt = 0;
      if (rr) m_exp = '0;
    end else if (v) begin
      if (m_have) begin
        m = (d == m_exp);
        if (!m_locked) begin
          if (m) begin
            m_good++;
            if (m_good == LOCK_N) begin m_locked = 1'b1; m_bad = 0; m_good = 0; end
          end else m_good = 0;
        end else if (m) begin
          m_bad = 0;
        end else begin
          m_pulse = 1'b1; m_error = 1'b1; m_cnt++; m_bad++;
          if (m_bad == LOSS_N) begin m_locked = 1'b0; m_good = 0; m_bad = 0; end
        end
      end
      m_exp  = prbs_next(d);
      m_have = 1'b1;
    end
    exp_a = CNT_EN ? ((m_cnt > 65535) ? 65535 : m_cnt) : 0;
    exp_b = CNT_EN ? ((m_cnt > 3) ? 3 : m_cnt) : 0;
    if (bus_a.err_pulse === 1'b1) pulses++;
    chk("a.locked",    {31'd0, bus_a.locked},    {31'd0, m_locked});
    chk("a.err_pulse", {31'd0, bus_a.err_pulse}, {31'd0, m_pulse});
    chk("a.error",     {31'd0, bus_a.error},     {31'd0, m_error});
    chk("a.err_count", {16'd0, bus_a.err_count}, exp_a);
    chk("b.locked",    {31'd0, bus_b.locked},    {31'd0, m_locked});
    chk("b.err_pulse", {31'd0, bus_b.err_pulse}, {31'd0, m_pulse});
    chk("b.error",     {31'd0, bus_b.error},     {31'd0, m_error});
    chk("b.err_count", {30'd0, bus_b.err_count}, exp_b);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic send(input int i);
    step(1'b1, W[i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] tx, word;
    int r;
    W[0] = 32'h0000_0001;
    for (int i = 1; i <= 40; i++) W[i] = prbs_next(W[i-1]);
    m_locked = 0; m_have = 0; m_pulse = 0; m_error = 0;
    m_good = 0; m_bad = 0; m_cnt = 0; m_exp = '0;

    // Reset state
    do_reset();
    chk("reset.locked", {31'd0, bus_a.locked}, 32'd0);
    chk("reset.error",  {31'd0, bus_a.error},  32'd0);
    chk("reset.count",  {16'd0, bus_a.err_count}, 32'd0);

    // 1. Lock after W4
    pulses = 0;
    for (int i = 0; i <= 3; i++) send(i);
    chk("s1.not_locked_W3", {31'd0, bus_a.locked}, 32'd0);
    send(4);
    chk("s1.locked_W4", {31'd0, bus_a.locked}, 32'd1);
    send(5);
    chk("s1.no_pulses", pulses, 32'd0);

    // 2. Single corruption while locked
    do_reset();
    for (int i = 0; i <= 9; i++) send(i);
    pulses = 0;
    step(1'b1, W[10] ^ 32'h1, 1'b0, 1'b0);
    for (int i = 11; i <= 14; i++) send(i);
    chk("s2.pulses", pulses, 32'd2);
    chk("s2.error",  {31'd0, bus_a.error}, 32'd1);
    chk("s2.locked", {31'd0, bus_a.locked}, 32'd1);
    chk("s2.count",  {16'd0, bus_a.err_count}, CNT_EN ? 32'd2 : 32'd0);

    // 5a. resync with coincident W15; W16 is the seed, lock after W20
    step(1'b1, W[15], 1'b1, 1'b0);
    chk("s5.rs_locked", {31'd0, bus_a.locked}, 32'd0);
    chk("s5.rs_error",  {31'd0, bus_a.error},  32'd0);
    chk("s5.rs_count",  {16'd0, bus_a.err_count}, 32'd0);
    for (int i = 16; i <= 19; i++) send(i);
    chk("s5.rs_not_yet", {31'd0, bus_a.locked}, 32'd0);
    send(20);
    chk("s5.rs_relock", {31'd0, bus_a.locked}, 32'd1);

    // 5b. Same with reset (overriding resync)
    do_reset();
    for (int i = 0; i <= 9; i++) send(i);
    step(1'b1, W[10] ^ 32'h1, 1'b0, 1'b0);
    for (int i = 11; i <= 14; i++) send(i);
    step(1'b1, W[15], 1'b1, 1'b1);
    chk("s5.rst_locked", {31'd0, bus_a.locked}, 32'd0);
    chk("s5.rst_error",  {31'd0, bus_a.error},  32'd0);
    for (int i = 16; i <= 19; i++) send(i);
    chk("s5.rst_not_yet", {31'd0, bus_a.locked}, 32'd0);
    send(20);
    chk("s5.rst_relock", {31'd0, bus_a.locked}, 32'd1);

    // 3. Loss of lock
    do_reset();
    for (int i = 0; i <= 5; i++) send(i);
    pulses = 0;
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("s3.locked_before_4th", {31'd0, bus_a.locked}, 32'd1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("s3.pulses", pulses, 32'd4);
    chk("s3.locked", {31'd0, bus_a.locked}, 32'd0);
    chk("s3.count",  {16'd0, bus_a.err_count}, CNT_EN ? 32'd4 : 32'd0);
    chk("s3.count_sat", {30'd0, bus_b.err_count}, CNT_EN ? 32'd3 : 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    chk("s3.search_no_pulse", pulses, 32'd0);

    // 4. Gaps of 3 idle cycles between beats
    do_reset();
    pulses = 0;
    for (int i = 0; i <= 8; i++) begin
      send(i);
      if (i == 3) chk("s4.not_locked_W3", {31'd0, bus_a.locked}, 32'd0);
      if (i == 4) chk("s4.locked_W4", {31'd0, bus_a.locked}, 32'd1);
      for (int g = 0; g < 3; g++) step(1'b0, $urandom, 1'b0, 1'b0);
    end
    chk("s4.no_pulses", pulses, 32'd0);

    // 6. Six non-consecutive-loss mismatches while locked: narrow counter saturates
    do_reset();
    for (int i = 0; i <= 5; i++) send(i);
    step(1'b1, W[6] ^ 32'h100, 1'b0, 1'b0);
    for (int i = 7; i <= 9; i++) send(i);
    step(1'b1, W[10] ^ 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 11; i <= 12; i++) send(i);
    step(1'b1, W[13] ^ 32'h4, 1'b0, 1'b0);
    send(14);
    chk("s6.locked", {31'd0, bus_a.locked}, 32'd1);
    chk("s6.count_a", {16'd0, bus_a.err_count}, CNT_EN ? 32'd6 : 32'd0);
    chk("s6.count_b", {30'd0, bus_b.err_count}, CNT_EN ? 32'd3 : 32'd0);

    // Randomized tail: mostly in-sequence beats with idles, flips, junk, resync and reset
    do_reset();
    tx = $urandom;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        step(1'b0, $urandom, 1'b0, 1'b0);
      end else if (r < 19) begin
        word = 32'h1 << $urandom_range(0, 31);
        step(1'b1, tx ^ word, 1'b0, 1'b0);
        tx = prbs_next(tx);
      end else if (r < 21) begin
        step($urandom_range(0, 1) == 1, tx, 1'b1, 1'b0);
      end else if (r < 22) begin
        step(1'b1, tx, 1'b1, 1'b1);
      end else if (r < 25) begin
        step(1'b1, $urandom, 1'b0, 1'b0);
        tx = prbs_next(tx);
      end else begin
        step(1'b1, tx, 1'b0, 1'b0);
        tx = prbs_next(tx);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
